// File: rtl/sc_inference_sequencer_if.sv
// rtl/sc_inference_sequencer_if.sv - control, status and bitstream bundle for the SC inference sequencer
interface sc_inference_sequencer_if #(
    parameter int N2 = 1,
    parameter int CW = 11,
    parameter int IW = 1
);
    logic              start;
    logic              abort;
    logic [N2-1:0]     net_dout;
    logic              net_reset;
    logic              sng_en;
    logic              busy;
    logic              done;
    logic              result_valid;
    logic [N2*CW-1:0]  count;
    logic [IW-1:0]     class_out;

    // Host / network side: issues requests, supplies bitstreams, observes status.
    modport master (
        output start,
        output abort,
        output net_dout,
        input  net_reset,
        input  sng_en,
        input  busy,
        input  done,
        input  result_valid,
        input  count,
        input  class_out
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  abort,
        input  net_dout,
        output net_reset,
        output sng_en,
        output busy,
        output done,
        output result_valid,
        output count,
        output class_out
    );
endinterface

// File: rtl/sc_inference_sequencer.sv
// rtl/sc_inference_sequencer.sv - clear/warmup/accumulate sequencer with argmax classifier for an SC network
module sc_inference_sequencer #(
    parameter int N2         = 1,
    parameter int STREAM_LEN = 1024,
    parameter int WARMUP     = 16,
    parameter int CLR_CYC    = 2
) (
    input  logic clk,
    input  logic reset,
    sc_inference_sequencer_if.slave bus
);

    localparam int CW = $clog2(STREAM_LEN + 1);
    localparam int IW = (N2 > 1) ? $clog2(N2) : 1;

    // The phase counter only needs to span the longest timed state.
    localparam int MAXA = (CLR_CYC > WARMUP) ? CLR_CYC : WARMUP;
    localparam int MAXP = (MAXA > STREAM_LEN) ? MAXA : STREAM_LEN;
    localparam int TW   = $clog2(MAXP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WARMUP,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   phase_q;
    logic [TW-1:0]   phase_d;

    logic [CW-1:0]   cnt_q [N2];
    logic [IW-1:0]   class_q;
    logic            valid_q;

    logic [IW-1:0]   best_idx;
    logic [CW-1:0]   best_val;

    logic            start_acc;
    logic            clr_last;
    logic            warm_last;
    logic            accum_last;

    assign start_acc  = (state_q == S_IDLE) && bus.start;
    assign clr_last   = (int'(phase_q) == CLR_CYC - 1);
    assign warm_last  = (int'(phase_q) == WARMUP - 1);
    assign accum_last = (int'(phase_q) == STREAM_LEN - 1);

    // State and phase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next-state and phase sequencing; abort only matters in the three timed run states.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q + TW'(1);
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (bus.start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else if (clr_last) begin
                    state_d = (WARMUP == 0) ? S_ACCUM : S_WARMUP;
                    phase_d = '0;
                end
            end
            S_WARMUP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else if (warm_last) begin
                    state_d = S_ACCUM;
                    phase_d = '0;
                end
            end
            S_ACCUM: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else if (accum_last) begin
                    state_d = S_DONE;
                    phase_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Per-neuron ones counters: cleared on an accepted start, frozen on abort or outside ACCUM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < N2; j++) begin
                cnt_q[j] <= '0;
            end
        end else if (start_acc) begin
            for (int j = 0; j < N2; j++) begin
                cnt_q[j] <= '0;
            end
        end else if ((state_q == S_ACCUM) && !bus.abort) begin
            for (int j = 0; j < N2; j++) begin
                cnt_q[j] <= cnt_q[j] + CW'(bus.net_dout[j]);
            end
        end
    end

    // Argmax over the counters; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = cnt_q[0];
        for (int j = 1; j < N2; j++) begin
            if (cnt_q[j] > best_val) begin
                best_val = cnt_q[j];
                best_idx = IW'(j);
            end
        end
    end

    // Result capture in DONE; validity drops as soon as a new run is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            class_q <= '0;
            valid_q <= 1'b0;
        end else if (start_acc) begin
            valid_q <= 1'b0;
        end else if (state_q == S_DONE) begin
            class_q <= best_idx;
            valid_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < N2; g++) begin : g_flat
        assign bus.count[g*CW +: CW] = cnt_q[g];
    end

    // The network must be held in reset whenever the block itself is in reset.
    assign bus.net_reset    = reset | (state_q == S_CLEAR);
    assign bus.sng_en       = (state_q == S_WARMUP) || (state_q == S_ACCUM);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.result_valid = valid_q;
    assign bus.class_out    = class_q;

endmodule

// File: tb/tb_sc_inference_sequencer.sv
// tb/tb_sc_inference_sequencer.sv - directed self-checking bench for sc_inference_sequencer
module tb_sc_inference_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    sc_inference_sequencer_if #(.N2(2), .CW(5), .IW(1)) bus ();

    sc_inference_sequencer #(
        .N2(2),
        .STREAM_LEN(16),
        .WARMUP(4),
        .CLR_CYC(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.net_dout = 2'b00;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.net_reset !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.sng_en !== 1'b0 || bus.result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: net_reset=%b busy=%b done=%b sng_en=%b rv=%b, want 1 0 0 0 0",
                     bus.net_reset, bus.busy, bus.done, bus.sng_en, bus.result_valid);
        end
        n_checks++;
        if (bus.count !== 10'd0 || bus.class_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: count=%h class=%b, want 0 0", bus.count, bus.class_out);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.net_reset !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: net_reset=%b busy=%b, want 0 0", bus.net_reset, bus.busy);
        end
    endtask

    task automatic run_constant(input logic [1:0] pat, input int e0, input int e1, input int ecls);
        logic [4:0] x0;
        logic [4:0] x1;
        bit seen;
        x0 = 5'(e0);
        x1 = 5'(e1);
        seen = 0;
        bus.net_dout = pat;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (k == 1 || k == 2) begin
                n_checks++;
                if (bus.net_reset !== 1'b1 || bus.sng_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clear_phase k=%0d: net_reset=%b sng_en=%b, want 1 0", k, bus.net_reset, bus.sng_en);
                end
            end
            if (k == 3) begin
                n_checks++;
                if (bus.net_reset !== 1'b0 || bus.sng_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL warmup_entry: net_reset=%b sng_en=%b, want 0 1", bus.net_reset, bus.sng_en);
                end
            end
            if (bus.done === 1'b1) begin
                seen = 1;
                n_checks++;
                if (k != 23) begin
                    n_fail++;
                    $display("FAIL done_latency: done at cycle %0d after start edge, want 23", k);
                end
                n_checks++;
                if (bus.count[4:0] !== x0 || bus.count[9:5] !== x1) begin
                    n_fail++;
                    $display("FAIL run_counts: count0=%0d count1=%0d, want %0d %0d",
                             bus.count[4:0], bus.count[9:5], x0, x1);
                end
                n_checks++;
                if (bus.sng_en !== 1'b0 || bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_state: sng_en=%b busy=%b, want 0 1", bus.sng_en, bus.busy);
                end
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: done=0 after 40 cycles, want 1");
        end
        @(negedge clk);
        n_checks++;
        if (bus.result_valid !== 1'b1 || bus.class_out !== 1'(ecls) || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL result_hold: rv=%b class=%b done=%b busy=%b, want 1 %0d 0 0",
                     bus.result_valid, bus.class_out, bus.done, bus.busy, ecls);
        end
    endtask

    task automatic test_single();
        run_constant(2'b01, 16, 0, 0);
    endtask

    task automatic test_class1();
        run_constant(2'b10, 0, 16, 1);
    endtask

    task automatic test_tie();
        bit seen;
        seen = 0;
        bus.net_dout = 2'b11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (k >= 7 && k <= 22) begin
                bus.net_dout = {((k - 7) >= 6), ((k - 7) < 10)};
            end else begin
                bus.net_dout = 2'b11;
            end
            if (bus.done === 1'b1) begin
                seen = 1;
                n_checks++;
                if (bus.count[4:0] !== 5'd10 || bus.count[9:5] !== 5'd10) begin
                    n_fail++;
                    $display("FAIL tie_counts: count0=%0d count1=%0d, want 10 10", bus.count[4:0], bus.count[9:5]);
                end
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL tie_timeout: done=0 after 40 cycles, want 1");
        end
        @(negedge clk);
        n_checks++;
        if (bus.class_out !== 1'b0 || bus.result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_class: class=%b rv=%b, want 0 1", bus.class_out, bus.result_valid);
        end
    endtask

    task automatic test_abort();
        bit bad;
        bad = 0;
        bus.net_dout = 2'b11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            bus.start = (k == 2 || k == 6) ? 1'b1 : 1'b0;
            bus.abort = (k == 11) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.sng_en !== 1'b0 || bus.done !== 1'b0 || bus.result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_exit: busy=%b sng_en=%b done=%b rv=%b, want 0 0 0 0",
                     bus.busy, bus.sng_en, bus.done, bus.result_valid);
        end
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1 || bus.busy !== 1'b0) bad = 1;
            @(negedge clk);
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL abort_quiet: done or busy seen after abort, want neither");
        end
    endtask

    task automatic test_start_with_abort();
        bit seen;
        seen = 0;
        bus.net_dout = 2'b11;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy=%b, want 1", bus.busy);
        end
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (bus.done === 1'b1) begin
                seen = 1;
                bus.abort = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL start_abort_timeout: done=0 after 40 cycles, want 1");
        end
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++;
        if (bus.result_valid !== 1'b1 || bus.count[4:0] !== 5'd16 || bus.count[9:5] !== 5'd16 ||
            bus.class_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_done: rv=%b count0=%0d count1=%0d class=%b, want 1 16 16 0",
                     bus.result_valid, bus.count[4:0], bus.count[9:5], bus.class_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] pats [3];
        int e0 [3];
        int e1 [3];
        logic ecls [3];
        int runs;
        int last;
        bit pend;
        pats = '{2'b01, 2'b10, 2'b11};
        e0 = '{16, 0, 16};
        e1 = '{0, 16, 16};
        ecls = '{1'b0, 1'b1, 1'b0};
        runs = 0;
        last = 0;
        pend = 0;
        bus.net_dout = pats[0];
        bus.start = 1'b1;
        for (int k = 1; k <= 100 && runs < 3; k++) begin
            @(negedge clk);
            if (pend) begin
                pend = 0;
                n_checks++;
                if (bus.result_valid !== 1'b1 || bus.class_out !== ecls[runs-1]) begin
                    n_fail++;
                    $display("FAIL b2b_result run %0d: rv=%b class=%b, want 1 %b",
                             runs - 1, bus.result_valid, bus.class_out, ecls[runs-1]);
                end
            end
            if (bus.done === 1'b1) begin
                n_checks++;
                if (bus.count[4:0] !== 5'(e0[runs]) || bus.count[9:5] !== 5'(e1[runs])) begin
                    n_fail++;
                    $display("FAIL b2b_counts run %0d: count0=%0d count1=%0d, want %0d %0d",
                             runs, bus.count[4:0], bus.count[9:5], e0[runs], e1[runs]);
                end
                n_checks++;
                if (k - last != ((runs == 0) ? 23 : 24)) begin
                    n_fail++;
                    $display("FAIL b2b_spacing run %0d: gap %0d, want %0d", runs, k - last, (runs == 0) ? 23 : 24);
                end
                last = k;
                runs++;
                pend = 1;
                if (runs < 3) bus.net_dout = pats[runs];
                else bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (runs != 3) begin
            n_fail++;
            $display("FAIL b2b_runs: %0d done pulses, want 3", runs);
        end
        @(negedge clk);
        n_checks++;
        if (bus.result_valid !== 1'b1 || bus.class_out !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_final: rv=%b class=%b busy=%b, want 1 0 0", bus.result_valid, bus.class_out, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        bus.net_dout = 2'b11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.sng_en !== 1'b0 || bus.net_reset !== 1'b1 || bus.done !== 1'b0 ||
            bus.count !== 10'd0 || bus.result_valid !== 1'b0 || bus.class_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b sng_en=%b net_reset=%b done=%b count=%h rv=%b class=%b, want 0 0 1 0 0 0 0",
                     bus.busy, bus.sng_en, bus.net_reset, bus.done, bus.count, bus.result_valid, bus.class_out);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.net_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: busy=%b net_reset=%b, want 0 0", bus.busy, bus.net_reset);
        end
        run_constant(2'b01, 16, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_class1();
        test_tie();
        test_abort();
        test_start_with_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_inference_sequencer.md
SC_INFERENCE_SEQUENCER -- requirements
Module: sc_inference_sequencer

Interface
REQ-001 SHALL have parameter N2, default 1: number of network output neurons to accumulate.
REQ-002 SHALL have parameter STREAM_LEN, default 1024: number of accumulation cycles per inference (bitstream length), >=2.
REQ-003 SHALL have parameter WARMUP, default 16: discarded settle cycles before accumulation, >=0.
REQ-004 SHALL have parameter CLR_CYC, default 2: cycles of network reset per inference, >=1.
REQ-005 SHALL derive CW = $clog2(STREAM_LEN+1) and IW = max($clog2(N2),1).
REQ-006 SHALL have the following ports:
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-high reset.
  start  in  1  request an inference; sampled only in IDLE.
  abort  in  1  cancel an inference in progress.
  net_dout  in  N2  output bitstreams from the SC network.
  net_reset  out  1  reset to the network neurons and SNG state.
  sng_en  out  1  enables stochastic number generators and network evaluation.
  busy  out  1  high in every state except IDLE.
  done  out  1  one-cycle completion pulse.
  result_valid  out  1  count/class_out hold a completed result.
  count  out  N2*CW  per-output ones count, flattened; neuron j at bits [j*CW +: CW].
  class_out  out  IW  index of the largest count.

Function
REQ-007 SHALL implement states IDLE, CLEAR, WARMUP, ACCUM and DONE.
REQ-008 IDLE: start=1 at an edge SHALL move to CLEAR, clear all count fields, and clear result_valid.
REQ-009 CLEAR SHALL last exactly CLR_CYC cycles with net_reset=1 and sng_en=0, then go to WARMUP (or ACCUM if WARMUP=0).
REQ-010 WARMUP SHALL last exactly WARMUP cycles with sng_en=1; net_dout SHALL be ignored.
REQ-011 ACCUM SHALL last exactly STREAM_LEN cycles with sng_en=1; at each edge in ACCUM, count[j] SHALL increment by net_dout[j].
REQ-012 Counts SHALL never overflow; maximum value is STREAM_LEN and fits in CW bits.
REQ-013 DONE SHALL last one cycle with done=1 and sng_en=0, register class_out, set result_valid=1, then go to IDLE.
REQ-014 class_out SHALL be the index j of the maximum count[j]; on ties, the lowest index wins; for N2=1 it SHALL be 0.
REQ-015 Latency: with start accepted at edge t, done SHALL be high in the cycle after edge t+CLR_CYC+WARMUP+STREAM_LEN.
REQ-016 count, class_out and result_valid SHALL hold their values from DONE until the next accepted start.
REQ-017 start SHALL be ignored while busy=1; no request is queued.
REQ-018 abort=1 at an edge in CLEAR, WARMUP or ACCUM SHALL go to IDLE with no done, result_valid=0, and count values left undefined-but-stable (frozen).
REQ-019 abort SHALL be ignored in IDLE and DONE; start and abort together in IDLE SHALL start an inference.
REQ-020 start held high SHALL produce back-to-back inferences: the next run is accepted in the IDLE cycle after DONE.
REQ-021 net_reset SHALL equal reset OR (state==CLEAR), combinationally.
REQ-022 All other outputs SHALL be registered or decoded from the state register only.

Reset
REQ-023 Asynchronous reset SHALL force state IDLE, count=0, class_out=0, result_valid=0, done=0, and sng_en=0, with net_reset=1 while reset is asserted.
REQ-024 Reset asserted mid-inference SHALL discard the run; after release the block is in IDLE and awaits start.

Verification (N2=2, STREAM_LEN=16, WARMUP=4, CLR_CYC=2)
REQ-025 Reset applied then released -> all outputs 0 except net_reset (1 during reset, 0 after); busy=0.
REQ-026 start pulse at edge t with net_dout=2'b01 held -> net_reset high for 2 cycles, done pulse in the cycle after edge t+22, count0=16, count1=0, class_out=0, result_valid=1.
REQ-027 net_dout[0] and net_dout[1] each high on 10 of 16 ACCUM cycles, plus 1s during WARMUP -> count0=10, count1=10, class_out=0 (tie).
REQ-028 abort on the 5th ACCUM cycle -> IDLE next cycle; busy=0, done never asserts, result_valid=0; extra start pulses while busy are ignored.
REQ-029 start held high for 3 runs -> three done pulses spaced 24 cycles apart, each run with counts re-cleared.
REQ-030 Asynchronous reset asserted mid-ACCUM between clock edges -> outputs clear immediately without waiting for a clock edge; the next start runs a normal full inference.
